// File: rtl/mem_port_if.sv
// Request/response bundle between the I/D cache requesters, the arbiter and the
// physical memory port. The arbiter takes the slave view; the environment the master view.
interface mem_port_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 256
);
    logic                  i_read;
    logic [ADDR_WIDTH-1:0] i_addr;
    logic                  i_resp;
    logic [LINE_WIDTH-1:0] i_rdata;

    logic                  d_read;
    logic                  d_write;
    logic [ADDR_WIDTH-1:0] d_addr;
    logic [LINE_WIDTH-1:0] d_wdata;
    logic                  d_resp;
    logic [LINE_WIDTH-1:0] d_rdata;

    logic                  pmem_read;
    logic                  pmem_write;
    logic [ADDR_WIDTH-1:0] pmem_addr;
    logic [LINE_WIDTH-1:0] pmem_wdata;
    logic                  pmem_resp;
    logic [LINE_WIDTH-1:0] pmem_rdata;

    modport slave (
        input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, pmem_resp, pmem_rdata,
        output i_resp, i_rdata, d_resp, d_rdata, pmem_read, pmem_write, pmem_addr, pmem_wdata
    );

    modport master (
        output i_read, i_addr, d_read, d_write, d_addr, d_wdata, pmem_resp, pmem_rdata,
        input  i_resp, i_rdata, d_resp, d_rdata, pmem_read, pmem_write, pmem_addr, pmem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one line-wide memory port between an I-side reader and a D-side reader/writer.
// D-side wins ties unless the I-side has been passed over STARVE_LIMIT times in a row.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int LINE_WIDTH   = 256,
    parameter int STARVE_LIMIT = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    mem_port_if.slave bus
);
    localparam int OFF_BITS = $clog2(LINE_WIDTH / 8);
    localparam int CNT_W    = $clog2(STARVE_LIMIT + 1);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK =
        {{(ADDR_WIDTH - OFF_BITS){1'b1}}, {OFF_BITS{1'b0}}};
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY, DONE} state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      starve_q, starve_d;
    logic                  pmem_read_q, pmem_read_d;
    logic                  pmem_write_q, pmem_write_d;
    logic [ADDR_WIDTH-1:0] pmem_addr_q, pmem_addr_d;
    logic [LINE_WIDTH-1:0] pmem_wdata_q, pmem_wdata_d;
    logic                  i_resp_q, i_resp_d;
    logic                  d_resp_q, d_resp_d;
    logic [LINE_WIDTH-1:0] i_rdata_q, i_rdata_d;
    logic [LINE_WIDTH-1:0] d_rdata_q, d_rdata_d;
    logic                  d_req;
    logic                  grant_i;

    // NOTE: every output below is assigned a default first so no path leaves a
    // variable unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d      = state_q;
        starve_d     = starve_q;
        pmem_read_d  = pmem_read_q;
        pmem_write_d = pmem_write_q;
        pmem_addr_d  = pmem_addr_q;
        pmem_wdata_d = pmem_wdata_q;
        i_resp_d     = 1'b0;
        d_resp_d     = 1'b0;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;
        d_req        = bus.d_read | bus.d_write;
        grant_i      = bus.i_read & (~d_req | (starve_q == CNT_MAX));

        unique case (state_q)
            IDLE: begin
                if (grant_i) begin
                    state_d      = I_BUSY;
                    starve_d     = '0;
                    pmem_read_d  = 1'b1;
                    pmem_write_d = 1'b0;
                    pmem_addr_d  = bus.i_addr & ALIGN_MASK;
                end else if (d_req) begin
                    state_d      = D_BUSY;
                    // A write wins when the D-side raises both ops at once.
                    pmem_write_d = bus.d_write;
                    pmem_read_d  = ~bus.d_write;
                    pmem_addr_d  = bus.d_addr & ALIGN_MASK;
                    pmem_wdata_d = bus.d_wdata;
                    if (!bus.i_read)
                        starve_d = '0;
                    else if (starve_q != CNT_MAX)
                        starve_d = starve_q + CNT_W'(1);
                end
            end
            I_BUSY: begin
                if (bus.pmem_resp) begin
                    state_d     = DONE;
                    pmem_read_d = 1'b0;
                    i_rdata_d   = bus.pmem_rdata;
                    i_resp_d    = 1'b1;
                end
            end
            D_BUSY: begin
                if (bus.pmem_resp) begin
                    state_d      = DONE;
                    pmem_read_d  = 1'b0;
                    pmem_write_d = 1'b0;
                    if (!pmem_write_q)
                        d_rdata_d = bus.pmem_rdata;
                    d_resp_d = 1'b1;
                end
            end
            DONE: begin
                // Requests are deliberately not sampled here; the requester
                // uses this cycle to drop or change its request.
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the wide line/data registers are reset too, because every output,
    // data buses included, must read zero after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            starve_q     <= '0;
            pmem_read_q  <= 1'b0;
            pmem_write_q <= 1'b0;
            pmem_addr_q  <= '0;
            pmem_wdata_q <= '0;
            i_resp_q     <= 1'b0;
            d_resp_q     <= 1'b0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            starve_q     <= starve_d;
            pmem_read_q  <= pmem_read_d;
            pmem_write_q <= pmem_write_d;
            pmem_addr_q  <= pmem_addr_d;
            pmem_wdata_q <= pmem_wdata_d;
            i_resp_q     <= i_resp_d;
            d_resp_q     <= d_resp_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    assign bus.pmem_read  = pmem_read_q;
    assign bus.pmem_write = pmem_write_q;
    assign bus.pmem_addr  = pmem_addr_q;
    assign bus.pmem_wdata = pmem_wdata_q;
    assign bus.i_resp     = i_resp_q;
    assign bus.d_resp     = d_resp_q;
    assign bus.i_rdata    = i_rdata_q;
    assign bus.d_rdata    = d_rdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: inputs change and outputs are sampled on the
// falling edge, with the memory side played by hand.
module tb_mem_port_arbiter;
    localparam int AW = 32;
    localparam int LW = 256;
    localparam int SL = 4;

    localparam logic [LW-1:0] DATA_X  = {8{32'h1111_AAAA}};
    localparam logic [LW-1:0] DATA_Y  = {8{32'h2222_BBBB}};
    localparam logic [LW-1:0] DATA_W1 = {8{32'hCAFE_0001}};
    localparam logic [LW-1:0] DATA_W2 = {8{32'hBEEF_0002}};
    localparam logic [LW-1:0] DATA_W3 = {8{32'hD00D_0003}};
    localparam logic [LW-1:0] DATA_Z  = {8{32'h3333_CCCC}};
    localparam logic [LW-1:0] DATA_V  = {8{32'h4444_DDDD}};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_port_if #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) bus ();

    mem_port_arbiter #(
        .ADDR_WIDTH  (AW),
        .LINE_WIDTH  (LW),
        .STARVE_LIMIT(SL)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Waits (bounded) until the arbiter drives a memory op.
    task automatic wait_grant(input string tag);
        int n = 0;
        while (!(bus.pmem_read || bus.pmem_write) && n < 20) begin
            tick();
            n++;
        end
        check(tag, LW'(n < 20), LW'(1));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_i_resp"}, LW'(bus.i_resp), '0);
        check({tag, "_d_resp"}, LW'(bus.d_resp), '0);
        check({tag, "_pmem_read"}, LW'(bus.pmem_read), '0);
        check({tag, "_pmem_write"}, LW'(bus.pmem_write), '0);
        check({tag, "_pmem_addr"}, LW'(bus.pmem_addr), '0);
        check({tag, "_pmem_wdata"}, bus.pmem_wdata, '0);
        check({tag, "_i_rdata"}, bus.i_rdata, '0);
        check({tag, "_d_rdata"}, bus.d_rdata, '0);
    endtask

    initial begin
        logic exp_i;

        bus.i_read = 0; bus.i_addr = '0;
        bus.d_read = 0; bus.d_write = 0; bus.d_addr = '0; bus.d_wdata = '0;
        bus.pmem_resp = 0; bus.pmem_rdata = '0;

        // Power-on reset
        tick(); tick();
        check_all_zero("por");
        rst_n = 1'b1;
        tick();

        // Lone I read with a three-cycle memory
        bus.i_read = 1; bus.i_addr = 32'h0000_1234;
        tick();
        check("i_pmem_read_c1", LW'(bus.pmem_read), LW'(1));
        check("i_pmem_write_c1", LW'(bus.pmem_write), LW'(0));
        check("i_pmem_addr", LW'(bus.pmem_addr), LW'(32'h0000_1220));
        tick();
        check("i_pmem_read_c2", LW'(bus.pmem_read), LW'(1));
        tick();
        check("i_pmem_read_c3", LW'(bus.pmem_read), LW'(1));
        check("i_pmem_addr_c3", LW'(bus.pmem_addr), LW'(32'h0000_1220));
        check("i_resp_early", LW'(bus.i_resp), LW'(0));
        bus.pmem_resp = 1; bus.pmem_rdata = DATA_X;
        tick();
        bus.pmem_resp = 0; bus.i_read = 0;
        check("i_resp_pulse", LW'(bus.i_resp), LW'(1));
        check("i_rdata", bus.i_rdata, DATA_X);
        check("i_d_resp_quiet", LW'(bus.d_resp), LW'(0));
        check("i_pmem_read_drop", LW'(bus.pmem_read), LW'(0));
        tick();
        check("i_resp_one_cycle", LW'(bus.i_resp), LW'(0));
        check("i_rdata_hold", bus.i_rdata, DATA_X);

        // Simultaneous I read and D write: D first, then I
        bus.i_read = 1; bus.i_addr = 32'h0000_2000;
        bus.d_write = 1; bus.d_addr = 32'h0000_3047; bus.d_wdata = DATA_W1;
        tick();
        check("sim_pmem_write", LW'(bus.pmem_write), LW'(1));
        check("sim_pmem_read", LW'(bus.pmem_read), LW'(0));
        check("sim_pmem_addr", LW'(bus.pmem_addr), LW'(32'h0000_3040));
        check("sim_pmem_wdata", bus.pmem_wdata, DATA_W1);
        bus.pmem_resp = 1; bus.pmem_rdata = DATA_Z;
        tick();
        bus.pmem_resp = 0; bus.d_write = 0;
        check("sim_d_resp", LW'(bus.d_resp), LW'(1));
        check("sim_i_resp_quiet", LW'(bus.i_resp), LW'(0));
        check("sim_d_rdata_untouched", bus.d_rdata, '0);
        wait_grant("sim_i_grant");
        check("sim_i_pmem_read", LW'(bus.pmem_read), LW'(1));
        check("sim_i_pmem_addr", LW'(bus.pmem_addr), LW'(32'h0000_2000));
        bus.pmem_resp = 1; bus.pmem_rdata = DATA_Y;
        tick();
        bus.pmem_resp = 0; bus.i_read = 0;
        check("sim_i_resp", LW'(bus.i_resp), LW'(1));
        check("sim_i_rdata", bus.i_rdata, DATA_Y);
        tick();

        // Starvation guard: four D grants, then I, then D again
        bus.i_read = 1; bus.i_addr = 32'h0000_4000;
        bus.d_read = 1; bus.d_addr = 32'h0000_5000;
        for (int k = 0; k < 6; k++) begin
            exp_i = (k == 4);
            wait_grant("starve_grant");
            check("starve_pmem_read", LW'(bus.pmem_read), LW'(1));
            check("starve_addr", LW'(bus.pmem_addr), exp_i ? LW'(32'h0000_4000) : LW'(32'h0000_5000));
            bus.pmem_resp = 1; bus.pmem_rdata = LW'(k + 1);
            tick();
            bus.pmem_resp = 0;
            check("starve_i_resp", LW'(bus.i_resp), LW'(exp_i));
            check("starve_d_resp", LW'(bus.d_resp), LW'(!exp_i));
            if (exp_i) check("starve_i_rdata", bus.i_rdata, LW'(k + 1));
            else       check("starve_d_rdata", bus.d_rdata, LW'(k + 1));
            if (k == 5) begin
                bus.i_read = 0; bus.d_read = 0;
            end
        end
        tick();

        // Conflicting D op: write wins, d_rdata keeps the last read line
        bus.d_read = 1; bus.d_write = 1; bus.d_addr = 32'h0000_601F; bus.d_wdata = DATA_W2;
        tick();
        check("conf_pmem_write", LW'(bus.pmem_write), LW'(1));
        check("conf_pmem_read", LW'(bus.pmem_read), LW'(0));
        check("conf_pmem_addr", LW'(bus.pmem_addr), LW'(32'h0000_6000));
        check("conf_pmem_wdata", bus.pmem_wdata, DATA_W2);
        bus.pmem_resp = 1; bus.pmem_rdata = DATA_Z;
        tick();
        bus.pmem_resp = 0; bus.d_read = 0; bus.d_write = 0;
        check("conf_d_resp", LW'(bus.d_resp), LW'(1));
        check("conf_d_rdata_hold", bus.d_rdata, LW'(6));
        tick();

        // I request dropped mid-transaction still completes
        bus.i_read = 1; bus.i_addr = 32'h0000_7008;
        tick();
        check("abort_pmem_addr", LW'(bus.pmem_addr), LW'(32'h0000_7000));
        bus.i_read = 0;
        tick();
        check("abort_pmem_read_c2", LW'(bus.pmem_read), LW'(1));
        tick();
        check("abort_pmem_read_c3", LW'(bus.pmem_read), LW'(1));
        bus.pmem_resp = 1; bus.pmem_rdata = DATA_V;
        tick();
        bus.pmem_resp = 0;
        check("abort_i_resp", LW'(bus.i_resp), LW'(1));
        check("abort_i_rdata", bus.i_rdata, DATA_V);
        tick(); tick();
        check("abort_no_regrant", LW'(bus.pmem_read), LW'(0));

        // Reset during a D write drops it without a response
        bus.d_write = 1; bus.d_addr = 32'h0000_8000; bus.d_wdata = DATA_W3;
        tick();
        check("rst_pmem_write_before", LW'(bus.pmem_write), LW'(1));
        rst_n = 1'b0;
        tick();
        check_all_zero("rst");
        rst_n = 1'b1; bus.d_write = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("rst_no_d_resp", LW'(bus.d_resp), LW'(0));
            check("rst_no_pmem_write", LW'(bus.pmem_write), LW'(0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
